// File: rtl/multi_sound_pio.sv
// Multi-channel sound PIO: per-channel amount/enable registers driving
// shadowed PWM outputs, plus a synchronised input bank with edge capture
// and a maskable level interrupt. Avalon-MM slave, read latency 1.
module multi_sound_pio #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned AMT_W     = 8,
    parameter int unsigned IN_W      = 2,
    parameter int unsigned PRESCALE  = 256,
    parameter int unsigned EDGE_MODE = 0,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      write,
    input  logic [31:0]               writedata,
    input  logic                      read,
    output logic [31:0]               readdata,
    output logic                      irq,
    input  logic [IN_W-1:0]           in_port,
    output logic [CHANNELS*AMT_W-1:0] amount,
    output logic [CHANNELS-1:0]       sound_enable,
    output logic [CHANNELS-1:0]       pwm_out
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic                            gen_q, gen_d;
    logic [IN_W-1:0]                 mask_q, mask_d;
    logic [IN_W-1:0]                 cap_q, cap_d;
    logic [IN_W-1:0]                 w1c_c, edge_c;
    logic [IN_W-1:0]                 sync1_q, sync2_q, prev_q;
    logic [CHANNELS-1:0][AMT_W-1:0]  amt_q, amt_d;
    logic [CHANNELS-1:0][AMT_W-1:0]  sh_amt_q, sh_amt_d;
    logic [CHANNELS-1:0]             en_q, en_d;
    logic [CHANNELS-1:0]             sh_en_q, sh_en_d;
    logic [CHANNELS-1:0]             pwm_q, pwm_d;
    logic [CHANNELS-1:0]             se_q, se_d;
    logic [PRE_W-1:0]                pre_q, pre_d;
    logic [AMT_W-1:0]                cnt_q, cnt_d;
    logic                            tc_c, wrap_c;
    logic                            irq_q, irq_d;
    logic [31:0]                     rdata_q, rdata_d;

    // Bus register writes; EDGE_CAP writes only produce a clear mask
    always_comb begin
        gen_d  = gen_q;
        mask_d = mask_q;
        amt_d  = amt_q;
        en_d   = en_q;
        w1c_c  = '0;
        if (write) begin
            if (address == ADDR_W'(0)) gen_d  = writedata[0];
            if (address == ADDR_W'(2)) w1c_c  = writedata[IN_W-1:0];
            if (address == ADDR_W'(3)) mask_d = writedata[IN_W-1:0];
            for (int n = 0; n < int'(CHANNELS); n++) begin
                if (address == ADDR_W'(4 + n)) begin
                    amt_d[n] = writedata[AMT_W-1:0];
                    en_d[n]  = writedata[AMT_W];
                end
            end
        end
    end

    // Edge qualification on the synchronised input; a new edge beats a W1C
    always_comb begin
        edge_c = sync2_q ^ prev_q;
        if (EDGE_MODE == 0)      edge_c = sync2_q & ~prev_q;
        else if (EDGE_MODE == 1) edge_c = ~sync2_q & prev_q;
        cap_d = (cap_q & ~w1c_c) | edge_c;
        irq_d = |(cap_q & mask_q);
    end

    // Prescaler, PWM counter, shadow reload at wrap and PWM compare
    always_comb begin
        tc_c     = (pre_q == PRE_W'(PRESCALE - 1));
        pre_d    = tc_c ? '0 : pre_q + 1'b1;
        cnt_d    = tc_c ? cnt_q + 1'b1 : cnt_q;
        wrap_c   = tc_c && (cnt_q == '1);
        sh_amt_d = wrap_c ? amt_q : sh_amt_q;
        sh_en_d  = wrap_c ? en_q  : sh_en_q;
        se_d     = {CHANNELS{gen_q}} & en_q;
        pwm_d    = '0;
        for (int n = 0; n < int'(CHANNELS); n++) begin
            pwm_d[n] = gen_q & sh_en_q[n] & (cnt_q < sh_amt_q[n]);
        end
    end

    // Read data mux; unmapped addresses and idle cycles return 0
    always_comb begin
        rdata_d = '0;
        if (read) begin
            if (address == ADDR_W'(0)) rdata_d = 32'(gen_q);
            if (address == ADDR_W'(1)) rdata_d = 32'(sync2_q);
            if (address == ADDR_W'(2)) rdata_d = 32'(cap_q);
            if (address == ADDR_W'(3)) rdata_d = 32'(mask_q);
            for (int n = 0; n < int'(CHANNELS); n++) begin
                if (address == ADDR_W'(4 + n)) rdata_d = 32'({en_q[n], amt_q[n]});
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_q    <= 1'b0;
            mask_q   <= '0;
            cap_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            amt_q    <= '0;
            en_q     <= '0;
            sh_amt_q <= '0;
            sh_en_q  <= '0;
            pwm_q    <= '0;
            se_q     <= '0;
            pre_q    <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            gen_q    <= gen_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            amt_q    <= amt_d;
            en_q     <= en_d;
            sh_amt_q <= sh_amt_d;
            sh_en_q  <= sh_en_d;
            pwm_q    <= pwm_d;
            se_q     <= se_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign readdata     = rdata_q;
    assign irq          = irq_q;
    assign amount       = amt_q;
    assign sound_enable = se_q;
    assign pwm_out      = pwm_q;

endmodule

// File: doc/multi_sound_pio.md
Name: multi_sound_pio

Overview:
- Parametrised successor to the single-channel sound PIO (8-bit amount plus sound-enable conduit).
- Avalon-MM slave exposing CHANNELS amount/enable register pairs, each driving a glitch-free PWM output.
- Adds a synchronised sensor/button input bank with edge capture and a maskable level IRQ.
- Sits on the HPS lightweight bridge or the Nios bus; conduits go to the audio/actuator pins and the sensor pins.

Parameters:
- CHANNELS, 2, number of amount/PWM channels (1..12).
- AMT_W, 8, amount width and PWM counter width.
- IN_W, 2, number of external inputs with edge capture (1..32).
- PRESCALE, 256, clk cycles per PWM counter step (>=1).
- EDGE_MODE, 0, capture edge: 0 rising, 1 falling, 2 both.
- ADDR_W, 4, word address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  word address
- write  in  1  write strobe
- writedata  in  32  write data
- read  in  1  read strobe
- readdata  out  32  read data, valid 1 cycle after read
- irq  out  1  level interrupt
- in_port  in  IN_W  asynchronous external inputs
- amount  out  CHANNELS*AMT_W  register value per channel, ch0 in LSBs
- sound_enable  out  CHANNELS  per-channel enable AND global enable
- pwm_out  out  CHANNELS  PWM per channel

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous assert, active-low. Release is synchronous to clk.
- Reset values: all registers 0, PWM counter 0, prescaler 0, synchronisers 0. Outputs readdata, irq, amount, sound_enable and pwm_out are all 0.
- Register map (word addresses):
  - 0 CTRL: bit0 global enable (GEN).
  - 1 IN_DATA: RO, synchronised in_port.
  - 2 EDGE_CAP: RW1C.
  - 3 IRQ_MASK: RW, IN_W bits.
  - 4+n AMOUNT[n]: bits AMT_W-1:0 amount, bit AMT_W channel enable.
  - Unmapped addresses read 0; writes to them are ignored.
- Bus timing:
  - Writes take effect on the clock edge where write=1, with zero wait states.
  - Reads have fixed latency 1 and no waitrequest.
  - Unused readdata bits are 0.
  - write and read are never asserted together.
- Input path and edge detection:
  - in_port passes through a 2-FF synchroniser, then a delayed copy is kept for edge detection.
  - A qualifying edge (per EDGE_MODE) sets the matching EDGE_CAP bit 3 cycles after the pin changes.
- EDGE_CAP clearing: writing 1 clears the bit. If a new edge and a W1C on the same bit occur in the same cycle, the set wins.
- irq = OR(EDGE_CAP & IRQ_MASK), registered, so it follows EDGE_CAP by 1 cycle.
- PWM timing:
  - The prescaler counts 0..PRESCALE-1. On terminal count the AMT_W-bit PWM counter increments and wraps from 2^AMT_W-1 to 0.
  - The PWM period is PRESCALE*2^AMT_W cycles.
- PWM shadowing:
  - Each channel holds a shadow amount and enable, loaded only on the cycle where the PWM counter wraps to 0. Mid-period writes therefore never glitch the output.
  - The amount conduit reflects the register immediately, not the shadow.
- pwm_out[n] = GEN & shadow_en[n] & (pwm_cnt < shadow_amt[n]), registered.
  - Amount 0 gives constant 0.
  - Amount 2^AMT_W-1 gives high for all but one counter step per period.
- GEN=0: pwm_out and sound_enable are forced 0 on the next cycle. Counters keep running, so re-enabling resumes phase-aligned.
- Reset mid-period: all state returns to reset values immediately; no partial pulse continues.

Test Plan:
- Reset: assert reset_n=0 mid-operation with pwm_out high and irq=1 -> all outputs 0 asynchronously; every register reads 0 after release.
- PWM duty (AMT_W=8, PRESCALE=1, GEN=1):
  - Write AMOUNT[0]=0x140 (enable, amount 0x40) -> amount[7:0]=0x40 next cycle.
  - pwm_out[0] starts at the next counter wrap, then is high 64 of every 256 cycles.
- PWM glitch-free update: write amount 0xC0 at counter=0x20 of a 0x40 period -> current period still ends high-time at 0x40; the next period is high for 192 cycles.
- Edge capture (EDGE_MODE=0): pulse in_port[1] 0->1 -> EDGE_CAP reads 0x2 after 3 cycles.
  - With IRQ_MASK=0x2, irq=1 one cycle later.
  - Write EDGE_CAP=0x2 -> EDGE_CAP=0 and irq=0 the following cycle.
- Simultaneous set/clear: time a rising edge on in_port[0] to land on the same cycle as a W1C write of 0x1 -> EDGE_CAP[0] stays 1.
- Global disable and reads: with channels running, write CTRL=0 -> pwm_out=0 and sound_enable=0 next cycle.
  - Reading address 15 returns 0x00000000.
  - Reading IN_DATA returns in_port after 2-cycle synchronisation.
